// File: rtl/vga_text_update_ctrl.sv
// Write-side sequencer for the 80x30 text DDRAM: clears it after reset, then
// renders the BAM channel status line during vertical blanking on request.
module vga_text_update_ctrl (
  input  logic        i_clk_27,
  input  logic        i_arst,
  input  logic        i_on,
  input  logic        i_req,
  input  logic        i_vblank,
  input  logic        i_channel_alive,
  input  logic [6:0]  i_mapped_dc,
  input  logic [2:0]  i_prescaler_mode,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_wr_en,
  output logic [11:0] o_wr_addr,
  output logic [7:0]  o_wr_data
);

  localparam int unsigned TEXT_LENGTH = 49;
  localparam int unsigned DDRAM_CELLS = 2400;
  localparam int unsigned ADDR_W      = 12;
  localparam logic [7:0]  BLANK_CODE  = 8'hFF;

  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(DDRAM_CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_TXT = ADDR_W'(TEXT_LENGTH - 1);

  // Character codes used by the status line
  localparam logic [7:0] C_D     = 8'd3;
  localparam logic [7:0] C_C     = 8'd2;
  localparam logic [7:0] C_E     = 8'd4;
  localparam logic [7:0] C_M     = 8'd12;
  localparam logic [7:0] C_O     = 8'd14;
  localparam logic [7:0] C_P     = 8'd15;
  localparam logic [7:0] C_R     = 8'd17;
  localparam logic [7:0] C_S     = 8'd18;
  localparam logic [7:0] C_DIG0  = 8'd26;
  localparam logic [7:0] C_HASH  = 8'd36;
  localparam logic [7:0] C_COLON = 8'd37;
  localparam logic [7:0] C_PCT   = 8'd38;
  localparam logic [7:0] C_COMMA = 8'd39;
  localparam logic [7:0] C_SPACE = 8'd40;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_DIV     = 3'd3,
    ST_WAIT_VB = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              alive_q, alive_d;
  logic [2:0]        mode_q, mode_d;
  logic              hund_q, hund_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        units_q, units_d;
  logic [6:0]        rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic [6:0]        dc_clamp_c;
  logic [7:0]        text_code_c;

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;

  assign dc_clamp_c = (i_mapped_dc > 7'd100) ? 7'd100 : i_mapped_dc;

  // State register
  always_ff @(posedge i_clk_27 or negedge i_arst) begin
    if (!i_arst) state_q <= ST_CLEAR;
    else         state_q <= state_d;
  end

  // Next-state logic; display disable overrides everything
  always_comb begin
    state_d = state_q;
    if (!i_on) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_CLEAR:   if (i_vblank && (cnt_q == LAST_CLR)) state_d = ST_IDLE;
        ST_IDLE:    if (i_req || pending_q) state_d = ST_LATCH;
        ST_LATCH:   state_d = ST_DIV;
        ST_DIV:     if (rem_q < 7'd10) state_d = ST_WAIT_VB;
        ST_WAIT_VB: if (i_vblank) state_d = ST_WRITE;
        ST_WRITE:   if (i_vblank && (cnt_q == LAST_TXT)) state_d = ST_DONE;
        ST_DONE:    state_d = (pending_q || i_req) ? ST_LATCH : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Status-line character for the current write index
  always_comb begin
    text_code_c = C_SPACE;
    case (cnt_q[5:0])
      6'd0:    text_code_c = C_HASH;
      6'd2:    text_code_c = C_DIG0 + 8'd1;
      6'd4:    text_code_c = C_COLON;
      6'd6:    text_code_c = C_DIG0 + {7'd0, alive_q};
      6'd8:    text_code_c = C_COMMA;
      6'd10:   text_code_c = C_D;
      6'd12:   text_code_c = C_C;
      6'd14:   text_code_c = C_COLON;
      6'd16:   text_code_c = C_DIG0 + {7'd0, hund_q};
      6'd18:   text_code_c = C_DIG0 + {4'd0, tens_q};
      6'd20:   text_code_c = C_DIG0 + {4'd0, units_q};
      6'd22:   text_code_c = C_PCT;
      6'd24:   text_code_c = C_COMMA;
      6'd26:   text_code_c = C_P;
      6'd28:   text_code_c = C_R;
      6'd30:   text_code_c = C_E;
      6'd32:   text_code_c = C_S;
      6'd34:   text_code_c = C_C;
      6'd37:   text_code_c = C_M;
      6'd39:   text_code_c = C_O;
      6'd41:   text_code_c = C_D;
      6'd43:   text_code_c = C_E;
      6'd45:   text_code_c = C_COLON;
      6'd47:   text_code_c = C_DIG0 + {5'd0, mode_q};
      default: text_code_c = C_SPACE;
    endcase
  end

  // Output and datapath next values per state
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    alive_d   = alive_q;
    mode_d    = mode_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    units_d   = units_q;
    rem_d     = rem_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (!i_on) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      // Requests outside IDLE/DONE are remembered; IDLE and DONE consume them
      if (i_req) pending_d = 1'b1;
      case (state_q)
        ST_CLEAR: begin
          busy_d = 1'b1;
          if (i_vblank) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = BLANK_CODE;
            cnt_d     = (cnt_q == LAST_CLR) ? '0 : cnt_q + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          pending_d = 1'b0;
          cnt_d     = '0;
        end
        ST_LATCH: begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          alive_d = i_channel_alive;
          mode_d  = i_prescaler_mode;
          hund_d  = (dc_clamp_c == 7'd100);
          rem_d   = (dc_clamp_c == 7'd100) ? 7'd0 : dc_clamp_c;
          tens_d  = 4'd0;
          units_d = 4'd0;
        end
        ST_DIV: begin
          busy_d = 1'b1;
          if (rem_q >= 7'd10) begin
            rem_d  = rem_q - 7'd10;
            tens_d = tens_q + 4'd1;
          end else begin
            units_d = rem_q[3:0];
          end
        end
        ST_WAIT_VB: busy_d = 1'b1;
        ST_WRITE: begin
          busy_d = 1'b1;
          if (i_vblank) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = text_code_c;
            cnt_d     = cnt_q + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          done_d    = 1'b1;
          busy_d    = pending_q || i_req;
          pending_d = 1'b0;
        end
        default: busy_d = 1'b0;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk_27 or negedge i_arst) begin
    if (!i_arst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      alive_q   <= 1'b0;
      mode_q    <= 3'd0;
      hund_q    <= 1'b0;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      rem_q     <= 7'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= BLANK_CODE;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      alive_q   <= alive_d;
      mode_q    <= mode_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
